// File: rtl/ulpi_pkg.sv
// Shared constants for the ULPI register-write engine: widths, TXCMD prefix, idle data and FSM state codes.
package ulpi_pkg;

    localparam int unsigned ULPI_ADDR_W = 6;
    localparam int unsigned ULPI_DATA_W = 8;
    localparam int unsigned STATE_W     = 2;

    localparam logic [1:0]             TXCMD_REGW_PREFIX = 2'b10;
    localparam logic [ULPI_DATA_W-1:0] ULPI_IDLE_DATA    = 8'h00;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_TXCMD = 2'd1;
    localparam state_t ST_DATA  = 2'd2;
    localparam state_t ST_STOP  = 2'd3;

    // Immediate register-write TXCMD byte for a given register address.
    function automatic logic [ULPI_DATA_W-1:0] txcmd_regw(input logic [ULPI_ADDR_W-1:0] addr);
        return {TXCMD_REGW_PREFIX, addr};
    endfunction

endpackage

// File: rtl/ulpi_reg_write_if.sv
// Request and ULPI pad signals of the register-write engine.
// The master modport belongs to the control logic / PHY side, the slave modport to the engine.
interface ulpi_reg_write_if;
    import ulpi_pkg::*;

    logic                   PrW;
    logic                   busy;
    logic [ULPI_ADDR_W-1:0] ADDR;
    logic [ULPI_DATA_W-1:0] REG_VAL;
    logic                   DIR;
    logic                   NXT;
    logic [ULPI_DATA_W-1:0] DATA_I;
    logic [ULPI_DATA_W-1:0] DATA_O;
    logic                   STP;

    modport master (
        output PrW, ADDR, REG_VAL, DIR, NXT, DATA_I,
        input  busy, DATA_O, STP
    );

    modport slave (
        input  PrW, ADDR, REG_VAL, DIR, NXT, DATA_I,
        output busy, DATA_O, STP
    );

endinterface

// File: rtl/ulpi_reg_write.sv
// ULPI immediate register-write engine (TXCMD, data, STP) in the 60 MHz ULPI clock domain.
// Optional build macro ULPI_DIR_ABORT_EN: DIR=1 during TXCMD/DATA aborts and later restarts the write.
module ulpi_reg_write
    import ulpi_pkg::*;
(
    input  logic             clk_ULPI,
    input  logic             rst,
    ulpi_reg_write_if.slave  ulpi
);

    state_t                 state_q, state_d;
    logic [ULPI_ADDR_W-1:0] addr_q, addr_d;
    logic [ULPI_DATA_W-1:0] val_q, val_d;
    logic [ULPI_DATA_W-1:0] data_q, data_d;
    logic                   busy_q, busy_d;
    logic                   stp_q, stp_d;

    // DATA_I is part of the pad interface but this block never turns the bus around.
    logic unused_data_i;
    assign unused_data_i = ^ulpi.DATA_I;

    always_ff @(posedge clk_ULPI or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            val_q   <= '0;
            data_q  <= ULPI_IDLE_DATA;
            busy_q  <= 1'b0;
            stp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            val_q   <= val_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            stp_q   <= stp_d;
        end
    end

    // Next state and next registered outputs.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        val_d   = val_q;
        data_d  = data_q;
        busy_d  = busy_q;
        stp_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                data_d = ULPI_IDLE_DATA;
                if (!busy_q) begin
                    if (ulpi.PrW) begin
                        addr_d = ulpi.ADDR;
                        val_d  = ulpi.REG_VAL;
                        busy_d = 1'b1;
                        if (!ulpi.DIR) begin
                            state_d = ST_TXCMD;
                            data_d  = txcmd_regw(ulpi.ADDR);
                        end
                    end
                end else if (!ulpi.DIR) begin
                    // Request was held off by DIR; start it now from the latched copy.
                    state_d = ST_TXCMD;
                    data_d  = txcmd_regw(addr_q);
                end
            end

            ST_TXCMD: begin
                data_d = txcmd_regw(addr_q);
`ifdef ULPI_DIR_ABORT_EN
                if (ulpi.DIR) begin
                    state_d = ST_IDLE;
                    data_d  = ULPI_IDLE_DATA;
                end else
`endif
                if (ulpi.NXT) begin
                    state_d = ST_DATA;
                    data_d  = val_q;
                end
            end

            ST_DATA: begin
                data_d = val_q;
`ifdef ULPI_DIR_ABORT_EN
                if (ulpi.DIR) begin
                    state_d = ST_IDLE;
                    data_d  = ULPI_IDLE_DATA;
                end else
`endif
                if (ulpi.NXT) begin
                    state_d = ST_STOP;
                    stp_d   = 1'b1;
                    data_d  = ULPI_IDLE_DATA;
                end
            end

            default: begin
                state_d = ST_IDLE;
                data_d  = ULPI_IDLE_DATA;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign ulpi.DATA_O = data_q;
    assign ulpi.STP    = stp_q;
    assign ulpi.busy   = busy_q;

endmodule

// File: tb/tb_ulpi_reg_write.sv
// Self-checking bench for ulpi_reg_write: fixed vector tables, hand-written corner sequences and
// randomized traffic against a per-cycle transaction model.
module tb_ulpi_reg_write;

    logic clk_ULPI;
    logic rst;
    int   checks;
    int   errors;

    ulpi_reg_write_if ulpi ();

    ulpi_reg_write dut (
        .clk_ULPI (clk_ULPI),
        .rst      (rst),
        .ulpi     (ulpi)
    );

    initial clk_ULPI = 1'b0;
    always #5 clk_ULPI = ~clk_ULPI;

    // Reference model: where the write is (0 idle, 1 cmd byte, 2 data byte, 3 stop), plus request.
    int         m_phase;
    logic       m_busy;
    logic [5:0] m_addr;
    logic [7:0] m_val;
    int         stp_pulses;

    typedef struct {
        logic       prw;
        logic [5:0] addr;
        logic [7:0] val;
        logic       dir;
        logic       nxt;
        logic [7:0] exp_data;
        logic       exp_stp;
        logic       exp_busy;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %02h expected %02h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_busy  = 1'b0;
        m_addr  = '0;
        m_val   = '0;
    endtask

    function automatic logic [7:0] model_data();
        if (m_phase == 1) return {2'b10, m_addr};
        if (m_phase == 2) return m_val;
        return 8'h00;
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step(input logic prw, input logic [5:0] a, input logic [7:0] v,
                              input logic dir, input logic nxt);
        if (m_phase == 0) begin
            if (!m_busy && prw) begin
                m_busy = 1'b1;
                m_addr = a;
                m_val  = v;
            end
            if (m_busy && !dir) m_phase = 1;
        end else if (m_phase == 3) begin
            m_phase = 0;
            m_busy  = 1'b0;
        end else begin
`ifdef ULPI_DIR_ABORT_EN
            if (dir) m_phase = 0;
            else if (nxt) m_phase = m_phase + 1;
`else
            if (nxt) m_phase = m_phase + 1;
`endif
        end
    endtask

    // Apply inputs, take one clock edge, and compare all outputs against the model.
    task automatic cyc(input logic prw, input logic [5:0] a, input logic [7:0] v,
                       input logic dir, input logic nxt);
        ulpi.PrW     = prw;
        ulpi.ADDR    = a;
        ulpi.REG_VAL = v;
        ulpi.DIR     = dir;
        ulpi.NXT     = nxt;
        ulpi.DATA_I  = 8'($urandom);
        @(posedge clk_ULPI);
        #1;
        model_step(prw, a, v, dir, nxt);
        chk("data_o", ulpi.DATA_O, model_data());
        chk("stp", 8'(ulpi.STP), 8'(m_phase == 3));
        chk("busy", 8'(ulpi.busy), 8'(m_busy));
        if (ulpi.STP) stp_pulses++;
    endtask

    task automatic run_table(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            cyc(vecs[i].prw, vecs[i].addr, vecs[i].val, vecs[i].dir, vecs[i].nxt);
            chk("tbl_data", ulpi.DATA_O, vecs[i].exp_data);
            chk("tbl_stp", 8'(ulpi.STP), 8'(vecs[i].exp_stp));
            chk("tbl_busy", 8'(ulpi.busy), 8'(vecs[i].exp_busy));
        end
    endtask

    task automatic do_reset();
        @(negedge clk_ULPI);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_data", ulpi.DATA_O, 8'h00);
        chk("rst_stp", 8'(ulpi.STP), 8'h00);
        chk("rst_busy", 8'(ulpi.busy), 8'h00);
        model_reset();
        @(negedge clk_ULPI);
        rst = 1'b0;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        stp_pulses = 0;
        model_reset();
        ulpi.PrW = 0; ulpi.ADDR = '0; ulpi.REG_VAL = '0;
        ulpi.DIR = 0; ulpi.NXT = 0; ulpi.DATA_I = '0;

        // Basic write 16/AF; ADDR/REG_VAL change after acceptance must not matter.
        vecs[0] = '{1'b1, 6'h16, 8'hAF, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1};
        vecs[1] = '{1'b0, 6'h3F, 8'h00, 1'b0, 1'b1, 8'hAF, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 6'h3F, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1};
        vecs[3] = '{1'b0, 6'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 6'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        // NXT already high at acceptance (ignored in IDLE): 2F/BA.
        vecs[5] = '{1'b1, 6'h2F, 8'hBA, 1'b0, 1'b1, 8'hAF, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 6'h2F, 8'hBA, 1'b0, 1'b1, 8'hBA, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 6'h2F, 8'hBA, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1};
        // PrW on the edge busy falls is ignored, accepted one cycle later.
        vecs[8] = '{1'b1, 6'h01, 8'h55, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[9] = '{1'b1, 6'h01, 8'h55, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1};

        rst = 1'b1;
        #12;
        chk("por_data", ulpi.DATA_O, 8'h00);
        chk("por_busy", 8'(ulpi.busy), 8'h00);
        @(negedge clk_ULPI);
        rst = 1'b0;

        stp_pulses = 0;
        run_table(0, 4);
        run_table(5, 9);
        chk("table_stp_count", 8'(stp_pulses), 8'd2);

        // Reset while a transfer is in flight, then a clean write.
        do_reset();
        cyc(1, 6'h2F, 8'hBA, 0, 0);
        cyc(0, 6'h2F, 8'hBA, 0, 1);
        do_reset();
        cyc(1, 6'h2C, 8'hA1, 0, 0);
        chk("post_rst_cmd", ulpi.DATA_O, 8'hAC);
        cyc(0, 6'h2C, 8'hA1, 0, 1);
        chk("post_rst_val", ulpi.DATA_O, 8'hA1);
        cyc(0, 6'h2C, 8'hA1, 0, 1);
        chk("post_rst_stp", 8'(ulpi.STP), 8'h01);
        cyc(0, 6'h00, 8'h00, 0, 0);

        // NXT held low for five TXCMD cycles.
        cyc(1, 6'h0A, 8'h3C, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 6'h0A, 8'h3C, 0, 0);
            chk("nxt_wait_cmd", ulpi.DATA_O, 8'h8A);
        end
        cyc(0, 6'h0A, 8'h3C, 0, 1);
        chk("nxt_wait_val", ulpi.DATA_O, 8'h3C);
        cyc(0, 6'h0A, 8'h3C, 0, 1);
        cyc(0, 6'h00, 8'h00, 0, 0);

        // Second PrW mid-sequence ignored: exactly one STP pulse.
        stp_pulses = 0;
        cyc(1, 6'h11, 8'h22, 0, 0);
        cyc(1, 6'h33, 8'h44, 0, 1);
        cyc(1, 6'h33, 8'h44, 0, 1);
        cyc(0, 6'h00, 8'h00, 0, 0);
        cyc(0, 6'h00, 8'h00, 0, 0);
        chk("single_stp", 8'(stp_pulses), 8'd1);

        // DIR=1 at request: pending, TXCMD only after DIR falls.
        cyc(1, 6'h05, 8'h66, 1, 0);
        chk("dir_pend_busy", 8'(ulpi.busy), 8'h01);
        chk("dir_pend_data", ulpi.DATA_O, 8'h00);
        cyc(0, 6'h00, 8'h00, 1, 1);
        cyc(0, 6'h00, 8'h00, 1, 0);
        cyc(0, 6'h00, 8'h00, 0, 0);
        chk("dir_release_cmd", ulpi.DATA_O, 8'h85);
        cyc(0, 6'h00, 8'h00, 0, 1);
        chk("dir_release_val", ulpi.DATA_O, 8'h66);
        cyc(0, 6'h00, 8'h00, 0, 1);
        cyc(0, 6'h00, 8'h00, 0, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(3) == 0), 6'($urandom), 8'($urandom),
                ($urandom_range(4) == 0), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
